// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: bet intake, card requests over req/ack, hand scoring,
// coin settlement and result flags for the display layer.
module blackjack_round_ctrl #(
   parameter int START_COINS  = 10,
   parameter int DEALER_STAND = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       next_pulse,
   input  logic       hit_pulse,
   input  logic       stand_pulse,
   input  logic       double_pulse,
   input  logic [3:0] bet,
   input  logic       card_ack,
   input  logic [3:0] card_val,
   output logic       deal_req,
   output logic       deal_to,
   output logic [5:0] player_score,
   output logic [5:0] dealer_score,
   output logic [4:0] coin,
   output logic [2:0] phase,
   output logic       win,
   output logic       lose,
   output logic       draw
);
   typedef enum logic [2:0] {
      S_BET    = 3'd0,
      S_DEAL   = 3'd1,
      S_PLAYER = 3'd2,
      S_DEALER = 3'd3,
      S_RESULT = 3'd4,
      S_BROKE  = 3'd5
   } state_t;

   state_t     state_reg, state_next;
   logic [5:0] p_hard_reg, p_hard_next, d_hard_reg, d_hard_next;
   logic       p_ace_reg, p_ace_next, d_ace_reg, d_ace_next;
   logic [3:0] p_cnt_reg, p_cnt_next;
   logic [1:0] deal_cnt_reg, deal_cnt_next;
   logic [4:0] bet_reg, bet_next, coin_reg, coin_next;
   logic       req_reg, req_next, to_reg, to_next, dbl_reg, dbl_next;
   logic [5:0] p_score_reg, p_score_next, d_score_reg, d_score_next;
   logic       win_reg, win_next, lose_reg, lose_next, draw_reg, draw_next;
   logic       go_result;
   logic [5:0] coin_sum;

   function automatic logic [5:0] score_of(input logic [5:0] hard, input logic ace);
      return (ace && hard <= 6'd11) ? hard + 6'd10 : hard;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_BET;
         p_hard_reg   <= '0;
         d_hard_reg   <= '0;
         p_ace_reg    <= 1'b0;
         d_ace_reg    <= 1'b0;
         p_cnt_reg    <= '0;
         deal_cnt_reg <= '0;
         bet_reg      <= '0;
         coin_reg     <= 5'(START_COINS);
         req_reg      <= 1'b0;
         to_reg       <= 1'b0;
         dbl_reg      <= 1'b0;
         p_score_reg  <= '0;
         d_score_reg  <= '0;
         win_reg      <= 1'b0;
         lose_reg     <= 1'b0;
         draw_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         p_hard_reg   <= p_hard_next;
         d_hard_reg   <= d_hard_next;
         p_ace_reg    <= p_ace_next;
         d_ace_reg    <= d_ace_next;
         p_cnt_reg    <= p_cnt_next;
         deal_cnt_reg <= deal_cnt_next;
         bet_reg      <= bet_next;
         coin_reg     <= coin_next;
         req_reg      <= req_next;
         to_reg       <= to_next;
         dbl_reg      <= dbl_next;
         p_score_reg  <= p_score_next;
         d_score_reg  <= d_score_next;
         win_reg      <= win_next;
         lose_reg     <= lose_next;
         draw_reg     <= draw_next;
      end
   end

   assign coin_sum = {1'b0, coin_reg} + {1'b0, bet_reg};

   always_comb begin
      state_next    = state_reg;
      p_hard_next   = p_hard_reg;
      d_hard_next   = d_hard_reg;
      p_ace_next    = p_ace_reg;
      d_ace_next    = d_ace_reg;
      p_cnt_next    = p_cnt_reg;
      deal_cnt_next = deal_cnt_reg;
      bet_next      = bet_reg;
      coin_next     = coin_reg;
      req_next      = req_reg;
      to_next       = to_reg;
      dbl_next      = dbl_reg;
      win_next      = win_reg;
      lose_next     = lose_reg;
      draw_next     = draw_reg;
      go_result     = 1'b0;

      // A card is absorbed on the ack edge regardless of phase; req only exists in dealing phases.
      if (req_reg && card_ack) begin
         req_next = 1'b0;
         if (!to_reg) begin
            p_hard_next = p_hard_reg + {2'b00, card_val};
            p_ace_next  = p_ace_reg | (card_val == 4'd1);
            p_cnt_next  = p_cnt_reg + {3'b000, (p_cnt_reg != 4'd15)};
         end else begin
            d_hard_next = d_hard_reg + {2'b00, card_val};
            d_ace_next  = d_ace_reg | (card_val == 4'd1);
         end
      end

      case (state_reg)
         S_BET: begin
            if (next_pulse && bet != 4'd0 && {1'b0, bet} <= coin_reg) begin
               bet_next      = {1'b0, bet};
               p_hard_next   = '0;
               d_hard_next   = '0;
               p_ace_next    = 1'b0;
               d_ace_next    = 1'b0;
               p_cnt_next    = '0;
               deal_cnt_next = '0;
               dbl_next      = 1'b0;
               state_next    = S_DEAL;
            end
         end
         S_DEAL: begin
            if (!req_reg) begin
               req_next = 1'b1;
               to_next  = deal_cnt_reg[0];
            end else if (card_ack) begin
               deal_cnt_next = deal_cnt_reg + 2'd1;
               if (deal_cnt_reg == 2'd3) state_next = S_PLAYER;
            end
         end
         S_PLAYER: begin
            // Scores already include the last card here, so bust/double follow-up come first.
            if (!req_reg) begin
               if (p_score_reg > 6'd21) begin
                  go_result = 1'b1;
               end else if (dbl_reg || stand_pulse) begin
                  state_next = S_DEALER;
               end else if (hit_pulse) begin
                  req_next = 1'b1;
                  to_next  = 1'b0;
               end else if (double_pulse && p_cnt_reg == 4'd2 &&
                            {bet_reg, 1'b0} <= {1'b0, coin_reg}) begin
                  bet_next = {bet_reg[3:0], 1'b0};
                  dbl_next = 1'b1;
                  req_next = 1'b1;
                  to_next  = 1'b0;
               end
            end
         end
         S_DEALER: begin
            if (!req_reg) begin
               if (d_score_reg < 6'(DEALER_STAND)) begin
                  req_next = 1'b1;
                  to_next  = 1'b1;
               end else begin
                  go_result = 1'b1;
               end
            end
         end
         S_RESULT: begin
            if (next_pulse) begin
               win_next   = 1'b0;
               lose_next  = 1'b0;
               draw_next  = 1'b0;
               state_next = (coin_reg == 5'd0) ? S_BROKE : S_BET;
            end
         end
         default: ;
      endcase

      if (go_result) begin
         state_next = S_RESULT;
         if (p_score_reg > 6'd21 ||
             (d_score_reg <= 6'd21 && p_score_reg < d_score_reg)) begin
            lose_next = 1'b1;
            coin_next = coin_reg - bet_reg;
         end else if (d_score_reg > 6'd21 || p_score_reg > d_score_reg) begin
            win_next  = 1'b1;
            coin_next = coin_sum[5] ? 5'd31 : coin_sum[4:0];
         end else begin
            draw_next = 1'b1;
         end
      end

      p_score_next = score_of(p_hard_next, p_ace_next);
      d_score_next = score_of(d_hard_next, d_ace_next);
   end

   assign deal_req     = req_reg;
   assign deal_to      = to_reg;
   assign player_score = p_score_reg;
   assign dealer_score = d_score_reg;
   assign coin         = coin_reg;
   assign phase        = state_reg;
   assign win          = win_reg;
   assign lose         = lose_reg;
   assign draw         = draw_reg;
endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl: scripted rounds with hand-computed scores,
// flags and coin balances; inputs driven and outputs sampled on the falling edge.
module tb_blackjack_round_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       next_pulse = 1'b0, hit_pulse = 1'b0, stand_pulse = 1'b0, double_pulse = 1'b0;
   logic [3:0] bet = '0;
   logic       card_ack = 1'b0;
   logic [3:0] card_val = '0;
   logic       deal_req, deal_to, win, lose, draw;
   logic [5:0] player_score, dealer_score;
   logic [4:0] coin;
   logic [2:0] phase;
   int         errors = 0;
   int         checks = 0;

   blackjack_round_ctrl dut (
      .clk(clk), .reset(reset), .next_pulse(next_pulse), .hit_pulse(hit_pulse),
      .stand_pulse(stand_pulse), .double_pulse(double_pulse), .bet(bet),
      .card_ack(card_ack), .card_val(card_val), .deal_req(deal_req), .deal_to(deal_to),
      .player_score(player_score), .dealer_score(dealer_score), .coin(coin),
      .phase(phase), .win(win), .lose(lose), .draw(draw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {next_pulse, hit_pulse, stand_pulse, double_pulse, card_ack} = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_next();
      next_pulse = 1'b1; @(negedge clk); next_pulse = 1'b0;
   endtask
   task automatic pulse_hit();
      hit_pulse = 1'b1; @(negedge clk); hit_pulse = 1'b0;
   endtask
   task automatic pulse_stand();
      stand_pulse = 1'b1; @(negedge clk); stand_pulse = 1'b0;
   endtask
   task automatic pulse_double();
      double_pulse = 1'b1; @(negedge clk); double_pulse = 1'b0;
   endtask

   task automatic serve(input logic [3:0] v, input logic to);
      int n = 0;
      while (deal_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("serve_req", 8'(deal_req), 8'd1);
      chk("serve_to", 8'(deal_to), 8'(to));
      card_val = v;
      card_ack = 1'b1;
      @(negedge clk);
      card_ack = 1'b0;
   endtask

   task automatic wait_phase(input logic [2:0] p);
      int n = 0;
      while (phase !== p && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wait_phase", 8'(phase), 8'(p));
   endtask

   task automatic deal4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
      serve(a, 1'b0);
      serve(b, 1'b1);
      serve(c, 1'b0);
      serve(d, 1'b1);
   endtask

   initial begin
      // Reset state and rejected bets
      do_reset();
      chk("rst_coin", 8'(coin), 8'd10);
      chk("rst_phase", 8'(phase), 8'd0);
      chk("rst_req", 8'(deal_req), 8'd0);
      chk("rst_pscore", 8'(player_score), 8'd0);
      chk("rst_flags", 8'({win, lose, draw}), 8'd0);
      bet = 4'd0; pulse_next();
      chk("bet0_phase", 8'(phase), 8'd0);
      bet = 4'd11; pulse_next();
      chk("bet11_phase", 8'(phase), 8'd0);

      // Round: draw at 17/17
      bet = 4'd2; pulse_next();
      chk("r1_deal_phase", 8'(phase), 8'd1);
      deal4(4'd10, 4'd9, 4'd7, 4'd8);
      chk("r1_phase", 8'(phase), 8'd2);
      chk("r1_p", 8'(player_score), 8'd17);
      chk("r1_d", 8'(dealer_score), 8'd17);
      pulse_stand();
      wait_phase(3'd4);
      chk("r1_flags", 8'({win, lose, draw}), 8'b001);
      chk("r1_coin", 8'(coin), 8'd10);
      pulse_next();
      chk("r1_next_phase", 8'(phase), 8'd0);
      chk("r1_next_flags", 8'({win, lose, draw}), 8'd0);

      // Round: soft ace, hit hardens, dealer busts
      do_reset();
      bet = 4'd3; pulse_next();
      deal4(4'd1, 4'd10, 4'd5, 4'd6);
      chk("r2_p_soft", 8'(player_score), 8'd16);
      chk("r2_d", 8'(dealer_score), 8'd16);
      pulse_hit();
      serve(4'd9, 1'b0);
      chk("r2_p_hard", 8'(player_score), 8'd15);
      chk("r2_phase_hit", 8'(phase), 8'd2);
      pulse_stand();
      serve(4'd6, 1'b1);
      chk("r2_d_bust", 8'(dealer_score), 8'd22);
      wait_phase(3'd4);
      chk("r2_flags", 8'({win, lose, draw}), 8'b100);
      chk("r2_coin", 8'(coin), 8'd13);

      // Round: double down to 21
      do_reset();
      bet = 4'd4; pulse_next();
      deal4(4'd5, 4'd10, 4'd6, 4'd7);
      chk("r3_p", 8'(player_score), 8'd11);
      pulse_double();
      serve(4'd10, 1'b0);
      chk("r3_p21", 8'(player_score), 8'd21);
      wait_phase(3'd4);
      chk("r3_d", 8'(dealer_score), 8'd17);
      chk("r3_flags", 8'({win, lose, draw}), 8'b100);
      chk("r3_coin", 8'(coin), 8'd18);

      // Round: all-in bust, broke is absorbing
      do_reset();
      bet = 4'd10; pulse_next();
      deal4(4'd10, 4'd5, 4'd10, 4'd5);
      chk("r4_p", 8'(player_score), 8'd20);
      pulse_hit();
      serve(4'd5, 1'b0);
      chk("r4_p_bust", 8'(player_score), 8'd25);
      wait_phase(3'd4);
      chk("r4_flags", 8'({win, lose, draw}), 8'b010);
      chk("r4_coin", 8'(coin), 8'd0);
      pulse_next();
      chk("r4_broke", 8'(phase), 8'd5);
      bet = 4'd1; pulse_next(); pulse_hit();
      chk("r4_broke_stay", 8'(phase), 8'd5);
      do_reset();
      chk("r4_rst_coin", 8'(coin), 8'd10);
      chk("r4_rst_phase", 8'(phase), 8'd0);

      // Stalled ack, stand-over-hit priority
      bet = 4'd2; pulse_next();
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         chk("hold_req", 8'(deal_req), 8'd1);
         chk("hold_to", 8'(deal_to), 8'd0);
         @(negedge clk);
      end
      deal4(4'd10, 4'd9, 4'd7, 4'd8);
      hit_pulse = 1'b1; stand_pulse = 1'b1;
      @(negedge clk);
      hit_pulse = 1'b0; stand_pulse = 1'b0;
      chk("prio_phase", 8'(phase), 8'd3);
      chk("prio_req", 8'(deal_req), 8'd0);
      chk("prio_p", 8'(player_score), 8'd17);

      // Reset mid-deal, late ack ignored
      do_reset();
      bet = 4'd2; pulse_next();
      @(negedge clk);
      chk("mid_req", 8'(deal_req), 8'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_phase", 8'(phase), 8'd0);
      chk("mid_rst_req", 8'(deal_req), 8'd0);
      reset = 1'b0;
      card_val = 4'd9; card_ack = 1'b1;
      @(negedge clk);
      card_ack = 1'b0;
      chk("late_ack_p", 8'(player_score), 8'd0);
      chk("late_ack_phase", 8'(phase), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
